branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage consumer of the condition comparator's single-bit COMP_OUT result.
- Decides taken/not-taken for conditional branches and jumps, computes the target PC, and issues a registered one-cycle fetch redirect.
- Squashes FLUSH_SLOTS younger wrong-path instructions and produces the link-register writeback for JAL/JALR.
- Also keeps a saturating taken-branch performance counter.

Parameters:
- WIDTH, 32, data/PC width.
- FLUSH_SLOTS, 2, younger pipeline slots squashed after a redirect (legal range 1..7).
- CNT_W, 16, taken-branch counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EX_VALID  in  1  valid instruction in EX.
- STALL  in  1  pipeline hold; EX instruction is neither accepted nor retired.
- BR_TYPE  in  3  bit2 = link; bits1:0 = kind (00 none, 01 cond, 10 jump-imm, 11 jump-reg).
- COMP_OUT  in  1  comparator result; decode sets the comparator's F so that 1 means taken.
- PC_PLUS4  in  WIDTH  address of the next sequential instruction.
- IMM  in  WIDTH  sign-extended offset.
- REG_A  in  WIDTH  register operand for jump-reg.
- CNT_CLR  in  1  synchronous clear of the perf counter.
- REDIRECT  out  1  one-cycle redirect pulse.
- REDIRECT_PC  out  WIDTH  new fetch address.
- FLUSH  out  1  squash younger slots.
- LINK_WE  out  1  link writeback pulse.
- LINK_VAL  out  WIDTH  link value.
- TRAP_MISALIGN  out  1  misaligned target pulse.
- BR_TAKEN_CNT  out  CNT_W  taken-branch count.

Behaviour:
- Reset: all outputs 0, state IDLE, flush counter 0. The reset is asynchronous; asserting it mid-FLUSH drops FLUSH immediately.
- Accept condition: EX_VALID & ~STALL & state==IDLE. Inputs are sampled at that edge; all outputs are registered, giving 1-cycle latency.
- Taken rules:
  - kind 01: taken iff COMP_OUT.
  - kind 10 and 11: always taken.
  - kind 00: never taken.
- Target:
  - kinds 01 and 10: PC_PLUS4+IMM, truncated mod 2^WIDTH (wrap-around is legal).
  - kind 11: REG_A.
- Link: bit2 is honoured only with kind 10/11. Link-with-00/01 (100, 101) is treated as none; no error is raised.
- Taken with target[1:0]==00:
  - REDIRECT=1 and REDIRECT_PC=target for exactly one cycle.
  - Go to FLUSH with count=FLUSH_SLOTS.
  - BR_TAKEN_CNT increments.
  - If link: LINK_WE=1 and LINK_VAL=PC_PLUS4 for one cycle.
- Taken with target[1:0]!=00:
  - TRAP_MISALIGN=1 for one cycle.
  - No redirect, no flush, no link write, no count.
- Not taken: outputs stay 0; state stays IDLE.
- REDIRECT, LINK_WE and TRAP_MISALIGN are single-cycle pulses and fire even if STALL rises in that cycle. Fetch must take a redirect while stalled.
- FLUSH state:
  - FLUSH=1 while in FLUSH.
  - Count decrements on each edge with STALL=0; it holds while STALL=1.
  - Return to IDLE when the count reaches 0; FLUSH is 0 in that following cycle.
  - EX_VALID is ignored throughout (wrong-path work), including jumps and branches.
- Back-to-back: the first instruction after FLUSH ends is accepted normally. A taken branch accepted on the IDLE re-entry cycle restarts FLUSH.
- Counter: saturates at all-ones. CNT_CLR takes priority over a simultaneous increment, and the counter reads 0 on the next cycle.
- STALL with EX_VALID in IDLE: nothing is accepted; the instruction is re-evaluated when STALL drops, with inputs held by upstream.

Decomposition:
- Shared package dlx_branch_pkg holds:
  - the BR_KIND constants (NONE, COND, JIMM, JREG) and the BR_LINK bit index;
  - the IDLE/FLUSH state encoding;
  - the flush-counter width constant.
- Sub-module branch_target_gen (combinational) holds the kind decode, the taken decision, the target adder/mux and the misalign check. The top level holds the FSM, the output registers and the perf counter.

Test Plan:
1. COND taken: BR_TYPE=001, COMP_OUT=1, PC_PLUS4=0x100, IMM=0xFFFFFFF0 -> next cycle REDIRECT=1, REDIRECT_PC=0xF0; FLUSH=1 for 2 cycles; BR_TAKEN_CNT=1.
2. COND not taken: BR_TYPE=001, COMP_OUT=0 -> REDIRECT, FLUSH, LINK_WE all 0; CNT unchanged. Then BR_TYPE=000 with COMP_OUT=1 -> no redirect.
3. JALR: BR_TYPE=111, REG_A=0x2000, PC_PLUS4=0x44 -> REDIRECT_PC=0x2000, LINK_WE=1, LINK_VAL=0x44. Repeat with REG_A=0x2002 -> TRAP_MISALIGN=1; no REDIRECT, FLUSH or LINK_WE.
4. Flush under stall: taken J, then STALL=1 for 3 cycles during FLUSH -> FLUSH stays high 2+3 cycles. EX_VALID with BR_TYPE=010 during FLUSH -> no second redirect.
5. Reset mid-flush: assert RESET between edges while FLUSH=1 -> FLUSH, REDIRECT and BR_TAKEN_CNT drop to 0 without a clock edge. After release, a taken COND redirects normally.
6. Counter edges: CNT_W=4, 16 taken jumps -> saturates at 0xF. CNT_CLR on the same cycle as a taken branch -> CNT=0.

Source files
------------

// File: rtl/dlx_branch_pkg.sv
// Shared encodings for the EX-stage branch resolution logic.
package dlx_branch_pkg;

  // BR_TYPE[1:0] kind field
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JIMM = 2'b10;
  localparam logic [1:0] BR_JREG = 2'b11;

  // BR_TYPE bit that requests a link writeback
  localparam int BR_LINK = 2;

  // Flush down-counter width, enough for up to 7 squashed slots
  localparam int FCNT_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational decode: taken decision, target select and misalign check.
module branch_target_gen
  import dlx_branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       br_type,
  input  logic             comp_out,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] reg_a,
  output logic             taken,
  output logic             link,
  output logic             misalign,
  output logic [WIDTH-1:0] target
);

  logic [1:0] kind;
  assign kind = br_type[1:0];

  // Taken decision per branch kind
  always_comb begin
    taken = 1'b0;
    case (kind)
      BR_COND: taken = comp_out;
      BR_JIMM: taken = 1'b1;
      BR_JREG: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Link only meaningful on jumps; link+none/cond silently degrades to no link
  assign link = br_type[BR_LINK] & kind[1];

  // Register jumps take REG_A, everything else is PC-relative (wraps freely)
  assign target = (kind == BR_JREG) ? reg_a : pc_plus4 + imm;

  assign misalign = taken & (|target[1:0]);

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: redirect/flush FSM, link writeback, taken counter.
module branch_resolve
  import dlx_branch_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FLUSH_SLOTS = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EX_VALID,
  input  logic             STALL,
  input  logic [2:0]       BR_TYPE,
  input  logic             COMP_OUT,
  input  logic [WIDTH-1:0] PC_PLUS4,
  input  logic [WIDTH-1:0] IMM,
  input  logic [WIDTH-1:0] REG_A,
  input  logic             CNT_CLR,
  output logic             REDIRECT,
  output logic [WIDTH-1:0] REDIRECT_PC,
  output logic             FLUSH,
  output logic             LINK_WE,
  output logic [WIDTH-1:0] LINK_VAL,
  output logic             TRAP_MISALIGN,
  output logic [CNT_W-1:0] BR_TAKEN_CNT
);

  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_SLOTS);

  br_state_t         state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;

  logic             taken, link, misalign;
  logic [WIDTH-1:0] target;
  logic             accept, go, trap;

  branch_target_gen #(.WIDTH(WIDTH)) u_tgt (
    .br_type  (BR_TYPE),
    .comp_out (COMP_OUT),
    .pc_plus4 (PC_PLUS4),
    .imm      (IMM),
    .reg_a    (REG_A),
    .taken    (taken),
    .link     (link),
    .misalign (misalign),
    .target   (target)
  );

  // Wrong-path instructions during FLUSH are never accepted
  assign accept = EX_VALID & ~STALL & (state == ST_IDLE);
  assign go     = accept & taken & ~misalign;
  assign trap   = accept & taken & misalign;

  // State and flush counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state: enter FLUSH on redirect, count down on unstalled edges
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        if (!STALL) begin
          if (fcnt <= FCNT_W'(1)) begin
            state_nxt = ST_IDLE;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt - FCNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

  // FLUSH decodes straight off the state flop so reset drops it immediately
  assign FLUSH = (state == ST_FLUSH);

  // Single-cycle pulses; they clear on the next edge regardless of STALL
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      REDIRECT      <= 1'b0;
      REDIRECT_PC   <= '0;
      LINK_WE       <= 1'b0;
      LINK_VAL      <= '0;
      TRAP_MISALIGN <= 1'b0;
    end else begin
      REDIRECT      <= go;
      REDIRECT_PC   <= go ? target : '0;
      LINK_WE       <= go & link;
      LINK_VAL      <= (go & link) ? PC_PLUS4 : '0;
      TRAP_MISALIGN <= trap;
    end
  end

  // Saturating taken counter; clear beats increment
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      BR_TAKEN_CNT <= '0;
    else if (CNT_CLR)
      BR_TAKEN_CNT <= '0;
    else if (go && !(&BR_TAKEN_CNT))
      BR_TAKEN_CNT <= BR_TAKEN_CNT + CNT_W'(1);
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve (FLUSH_SLOTS=2, CNT_W=4).
module tb_branch_resolve;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             EX_VALID, STALL, COMP_OUT, CNT_CLR;
  logic [2:0]       BR_TYPE;
  logic [WIDTH-1:0] PC_PLUS4, IMM, REG_A;
  logic             REDIRECT, FLUSH, LINK_WE, TRAP_MISALIGN;
  logic [WIDTH-1:0] REDIRECT_PC, LINK_VAL;
  logic [CNT_W-1:0] BR_TAKEN_CNT;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  branch_resolve #(.WIDTH(WIDTH), .FLUSH_SLOTS(2), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .STALL(STALL),
    .BR_TYPE(BR_TYPE), .COMP_OUT(COMP_OUT), .PC_PLUS4(PC_PLUS4), .IMM(IMM),
    .REG_A(REG_A), .CNT_CLR(CNT_CLR), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .FLUSH(FLUSH), .LINK_WE(LINK_WE),
    .LINK_VAL(LINK_VAL), .TRAP_MISALIGN(TRAP_MISALIGN),
    .BR_TAKEN_CNT(BR_TAKEN_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, land 1 time unit after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int n);
    EX_VALID = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    RESET = 1'b1; EX_VALID = 0; STALL = 0; COMP_OUT = 0; CNT_CLR = 0;
    BR_TYPE = 3'b000; PC_PLUS4 = '0; IMM = '0; REG_A = '0;
    #2;
    chk("rst_redirect", {31'b0, REDIRECT}, 0);
    chk("rst_flush", {31'b0, FLUSH}, 0);
    chk("rst_cnt", {28'b0, BR_TAKEN_CNT}, 0);
    chk("rst_link", {31'b0, LINK_WE}, 0);
    step();
    RESET = 1'b0;
    step();

    // 1: COND taken with negative offset
    EX_VALID = 1; BR_TYPE = 3'b001; COMP_OUT = 1; PC_PLUS4 = 32'h100; IMM = 32'hFFFF_FFF0;
    step();
    chk("t1_redirect", {31'b0, REDIRECT}, 1);
    chk("t1_pc", REDIRECT_PC, 32'hF0);
    chk("t1_flush", {31'b0, FLUSH}, 1);
    chk("t1_cnt", {28'b0, BR_TAKEN_CNT}, 1);
    chk("t1_linkwe", {31'b0, LINK_WE}, 0);
    EX_VALID = 0;
    step();
    chk("t1_redirect_pulse", {31'b0, REDIRECT}, 0);
    chk("t1_flush2", {31'b0, FLUSH}, 1);
    step();
    chk("t1_flush_end", {31'b0, FLUSH}, 0);

    // 2: not taken, kind none, link+cond
    EX_VALID = 1; BR_TYPE = 3'b001; COMP_OUT = 0;
    step();
    chk("t2_nt_redirect", {31'b0, REDIRECT}, 0);
    chk("t2_nt_flush", {31'b0, FLUSH}, 0);
    chk("t2_nt_link", {31'b0, LINK_WE}, 0);
    chk("t2_nt_cnt", {28'b0, BR_TAKEN_CNT}, 1);
    BR_TYPE = 3'b000; COMP_OUT = 1;
    step();
    chk("t2_none_redirect", {31'b0, REDIRECT}, 0);
    chk("t2_none_cnt", {28'b0, BR_TAKEN_CNT}, 1);
    BR_TYPE = 3'b101; PC_PLUS4 = 32'h200; IMM = 32'h10;
    step();
    chk("t2_lcond_redirect", {31'b0, REDIRECT}, 1);
    chk("t2_lcond_pc", REDIRECT_PC, 32'h210);
    chk("t2_lcond_link", {31'b0, LINK_WE}, 0);
    chk("t2_lcond_cnt", {28'b0, BR_TAKEN_CNT}, 2);
    drain(2);

    // 3: JALR aligned, then misaligned
    EX_VALID = 1; BR_TYPE = 3'b111; REG_A = 32'h2000; PC_PLUS4 = 32'h44; IMM = 32'h3;
    step();
    chk("t3_redirect", {31'b0, REDIRECT}, 1);
    chk("t3_pc", REDIRECT_PC, 32'h2000);
    chk("t3_linkwe", {31'b0, LINK_WE}, 1);
    chk("t3_linkval", LINK_VAL, 32'h44);
    chk("t3_cnt", {28'b0, BR_TAKEN_CNT}, 3);
    drain(2);
    chk("t3_idle", {31'b0, FLUSH}, 0);
    EX_VALID = 1; REG_A = 32'h2002;
    step();
    chk("t3_trap", {31'b0, TRAP_MISALIGN}, 1);
    chk("t3_trap_redirect", {31'b0, REDIRECT}, 0);
    chk("t3_trap_flush", {31'b0, FLUSH}, 0);
    chk("t3_trap_link", {31'b0, LINK_WE}, 0);
    chk("t3_trap_cnt", {28'b0, BR_TAKEN_CNT}, 3);
    EX_VALID = 0;
    step();
    chk("t3_trap_pulse", {31'b0, TRAP_MISALIGN}, 0);

    // 4: flush held by stall, wrong-path jumps ignored, then back-to-back accept
    EX_VALID = 1; BR_TYPE = 3'b010; PC_PLUS4 = 32'h300; IMM = 32'h100;
    step();
    chk("t4_redirect", {31'b0, REDIRECT}, 1);
    chk("t4_pc", REDIRECT_PC, 32'h400);
    chk("t4_cnt", {28'b0, BR_TAKEN_CNT}, 4);
    STALL = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_stall_flush", {31'b0, FLUSH}, 1);
      chk("t4_stall_noredir", {31'b0, REDIRECT}, 0);
    end
    STALL = 0;
    step();
    chk("t4_flush_last", {31'b0, FLUSH}, 1);
    chk("t4_wrongpath_noredir", {31'b0, REDIRECT}, 0);
    step();
    chk("t4_flush_done", {31'b0, FLUSH}, 0);
    chk("t4_done_noredir", {31'b0, REDIRECT}, 0);
    chk("t4_done_cnt", {28'b0, BR_TAKEN_CNT}, 4);
    step();
    chk("t4_b2b_redirect", {31'b0, REDIRECT}, 1);
    chk("t4_b2b_cnt", {28'b0, BR_TAKEN_CNT}, 5);
    drain(2);

    // stall in IDLE holds the instruction until stall drops
    EX_VALID = 1; STALL = 1;
    step();
    chk("t4_idle_stall", {31'b0, REDIRECT}, 0);
    chk("t4_idle_stall_cnt", {28'b0, BR_TAKEN_CNT}, 5);
    STALL = 0;
    step();
    chk("t4_idle_release", {31'b0, REDIRECT}, 1);
    chk("t4_idle_release_cnt", {28'b0, BR_TAKEN_CNT}, 6);

    // 5: async reset mid-flush
    EX_VALID = 0;
    step();
    chk("t5_in_flush", {31'b0, FLUSH}, 1);
    #2 RESET = 1;
    #1;
    chk("t5_rst_flush", {31'b0, FLUSH}, 0);
    chk("t5_rst_redirect", {31'b0, REDIRECT}, 0);
    chk("t5_rst_cnt", {28'b0, BR_TAKEN_CNT}, 0);
    #1 RESET = 0;
    EX_VALID = 1; BR_TYPE = 3'b001; COMP_OUT = 1; PC_PLUS4 = 32'h600; IMM = 32'h8;
    step();
    chk("t5_after_redirect", {31'b0, REDIRECT}, 1);
    chk("t5_after_pc", REDIRECT_PC, 32'h608);
    chk("t5_after_cnt", {28'b0, BR_TAKEN_CNT}, 1);
    drain(2);

    // 6: saturation and clear priority
    BR_TYPE = 3'b010; PC_PLUS4 = 32'h1000; IMM = 32'h0;
    for (int i = 0; i < 16; i++) begin
      EX_VALID = 1;
      step();
      drain(2);
    end
    chk("t6_sat", {28'b0, BR_TAKEN_CNT}, 32'hF);
    EX_VALID = 1; CNT_CLR = 1;
    step();
    chk("t6_clr_redirect", {31'b0, REDIRECT}, 1);
    chk("t6_clr_cnt", {28'b0, BR_TAKEN_CNT}, 0);
    CNT_CLR = 0;
    drain(2);
    chk("t6_clr_hold", {28'b0, BR_TAKEN_CNT}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
